branch_predictor_btb: RTL and testbench

- Parametrised dynamic branch predictor and branch target buffer (BTB) for the 5-stage rv32i pipeline.
- Replaces static predict-not-taken with a prediction made in IF. The block predicts from the IF PC combinationally.
- It is trained at branch resolution in MEM, where the pipeline currently computes pcmux_sel and flush.
- Supports bimodal or gshare indexing and keeps branch and mispredict performance counters.

---
 rtl/branch_predictor_btb.sv | 78 +++++++
 tb/tb_branch_predictor_btb.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor_btb.sv
// branch_predictor_btb: bimodal/gshare direction predictor with BTB, predicts in IF, trained at MEM resolution
module branch_predictor_btb #(
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS = 8,
  parameter int CTR_BITS = 2,
  parameter int GSHARE = 0,
  parameter int GHR_BITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           pred_pc,
  output logic                  pred_hit,
  output logic                  pred_taken,
  output logic [31:0]           pred_target,
  output logic [INDEX_BITS-1:0] pred_index,
  input  logic                  upd_valid,
  input  logic [31:0]           upd_pc,
  input  logic [INDEX_BITS-1:0] upd_index,
  input  logic                  upd_is_br,
  input  logic                  upd_is_jump,
  input  logic                  upd_taken,
  input  logic [31:0]           upd_target,
  input  logic                  upd_mispredict,
  output logic [31:0]           perf_branches,
  output logic [31:0]           perf_mispredicts
);
  localparam int N = 1 << INDEX_BITS;
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  logic btb_valid [N];
  logic btb_jump [N];
  logic [TAG_BITS-1:0] btb_tag [N];
  logic [31:0] btb_target [N];
  logic [CTR_BITS-1:0] ctr [N];
  logic [GHR_BITS-1:0] ghr;
  logic [INDEX_BITS-1:0] p_bidx, u_bidx;
  logic [TAG_BITS-1:0] p_tag, u_tag;
  logic [CTR_BITS-1:0] u_ctr;
  logic upd_any, upd_br, unused;
  assign unused = &{1'b0, pred_pc, upd_pc};
  always_comb begin
    p_bidx = pred_pc[INDEX_BITS+1:2];
    p_tag = pred_pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
    u_bidx = upd_pc[INDEX_BITS+1:2];
    u_tag = upd_pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
    pred_index = GSHARE != 0 ? p_bidx ^ INDEX_BITS'(ghr) : p_bidx;
    pred_hit = btb_valid[p_bidx] && btb_tag[p_bidx] == p_tag;
    pred_taken = pred_hit && (btb_jump[p_bidx] || ctr[pred_index][CTR_BITS-1]);
    pred_target = pred_taken ? btb_target[p_bidx] : pred_pc + 32'd4;
    upd_any = upd_valid && (upd_is_br || upd_is_jump);
    upd_br = upd_valid && upd_is_br && !upd_is_jump;
    u_ctr = ctr[upd_index];
    u_ctr = upd_taken ? (&u_ctr ? u_ctr : u_ctr + CTR_BITS'(1)) : (|u_ctr ? u_ctr - CTR_BITS'(1) : u_ctr);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        btb_valid[i] <= 1'b0;
        ctr[i] <= CTR_INIT;
      end
      ghr <= '0;
      perf_branches <= '0;
      perf_mispredicts <= '0;
    end else if (upd_any) begin
      if (upd_br) begin
        ctr[upd_index] <= u_ctr;
        if (GSHARE != 0) ghr <= GHR_BITS'({ghr, upd_taken});
      end
      if (upd_taken) begin
        btb_valid[u_bidx] <= 1'b1;
        btb_tag[u_bidx] <= u_tag;
        btb_target[u_bidx] <= upd_target;
        btb_jump[u_bidx] <= upd_is_jump;
      end
      perf_branches <= perf_branches + 32'd1;
      perf_mispredicts <= perf_mispredicts + {31'd0, upd_mispredict};
    end
  end
endmodule

// File: tb/tb_branch_predictor_btb.sv
// tb_branch_predictor_btb: bimodal and gshare instances checked against a table model plus directed literals
module tb_branch_predictor_btb;
  logic clk = 0;
  logic rst;
  logic [31:0] pred_pc;
  logic upd_valid, upd_is_br, upd_is_jump, upd_taken, upd_mispredict;
  logic [31:0] upd_pc, upd_target;
  logic [5:0] upd_index;
  logic hit [2];
  logic tk [2];
  logic [31:0] tgt [2];
  logic [5:0] idx [2];
  logic [31:0] pb [2];
  logic [31:0] pm [2];
  int n_checks = 0;
  int n_fail = 0;
  bit live = 0;
  bit mv [2][64];
  bit mj [2][64];
  int mt [2][64];
  logic [31:0] mtg [2][64];
  int mc [2][64];
  int mghr [2];
  int mpb [2];
  int mpm [2];
  always #5 clk = ~clk;
  branch_predictor_btb d0 (
    .clk(clk), .rst(rst), .pred_pc(pred_pc), .pred_hit(hit[0]), .pred_taken(tk[0]),
    .pred_target(tgt[0]), .pred_index(idx[0]), .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_index(upd_index), .upd_is_br(upd_is_br), .upd_is_jump(upd_is_jump), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_mispredict(upd_mispredict), .perf_branches(pb[0]), .perf_mispredicts(pm[0])
  );
  branch_predictor_btb #(.GSHARE(1), .GHR_BITS(4)) d1 (
    .clk(clk), .rst(rst), .pred_pc(pred_pc), .pred_hit(hit[1]), .pred_taken(tk[1]),
    .pred_target(tgt[1]), .pred_index(idx[1]), .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_index(upd_index), .upd_is_br(upd_is_br), .upd_is_jump(upd_is_jump), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_mispredict(upd_mispredict), .perf_branches(pb[1]), .perf_mispredicts(pm[1])
  );
  function automatic int bidx(input logic [31:0] pc);
    return int'((pc >> 2) & 32'd63);
  endfunction
  function automatic int tagf(input logic [31:0] pc);
    return int'((pc >> 8) & 32'd255);
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(posedge clk) begin : model
    int b;
    if (rst) begin
      live = 1;
      for (int g = 0; g < 2; g++) begin
        for (int i = 0; i < 64; i++) begin
          mv[g][i] = 0;
          mc[g][i] = 1;
        end
        mghr[g] = 0;
        mpb[g] = 0;
        mpm[g] = 0;
      end
    end else if (upd_valid && (upd_is_br || upd_is_jump)) begin
      b = bidx(upd_pc);
      for (int g = 0; g < 2; g++) begin
        if (upd_is_br && !upd_is_jump) begin
          if (upd_taken) mc[g][upd_index] = mc[g][upd_index] < 3 ? mc[g][upd_index] + 1 : 3;
          else mc[g][upd_index] = mc[g][upd_index] > 0 ? mc[g][upd_index] - 1 : 0;
          if (g == 1) mghr[g] = (mghr[g] * 2 + int'(upd_taken)) % 16;
        end
        if (upd_taken) begin
          mv[g][b] = 1;
          mt[g][b] = tagf(upd_pc);
          mtg[g][b] = upd_target;
          mj[g][b] = upd_is_jump;
        end
        mpb[g]++;
        mpm[g] += int'(upd_mispredict);
      end
    end
  end
  always @(negedge clk) begin : compare
    int b, ix;
    bit h, t;
    logic [31:0] tg;
    if (live) begin
      b = bidx(pred_pc);
      for (int g = 0; g < 2; g++) begin
        ix = g == 1 ? (b ^ mghr[g]) : b;
        h = mv[g][b] && mt[g][b] == tagf(pred_pc);
        t = h && (mj[g][b] || mc[g][ix] >= 2);
        tg = t ? mtg[g][b] : pred_pc + 32'd4;
        chk($sformatf("m_hit%0d", g), {31'd0, hit[g]}, {31'd0, h});
        chk($sformatf("m_taken%0d", g), {31'd0, tk[g]}, {31'd0, t});
        chk($sformatf("m_target%0d", g), tgt[g], tg);
        chk($sformatf("m_index%0d", g), {26'd0, idx[g]}, ix);
        chk($sformatf("m_perf_br%0d", g), pb[g], mpb[g]);
        chk($sformatf("m_perf_mis%0d", g), pm[g], mpm[g]);
      end
    end
  end
  task automatic upd(input logic [31:0] pc, input logic [5:0] ix, input logic br, input logic jmp,
                     input logic t, input logic [31:0] target, input logic mis);
    upd_valid = 1;
    upd_pc = pc;
    upd_index = ix;
    upd_is_br = br;
    upd_is_jump = jmp;
    upd_taken = t;
    upd_target = target;
    upd_mispredict = mis;
    @(posedge clk);
    #1 upd_valid = 0;
  endtask
  task automatic at(input logic [31:0] pc);
    pred_pc = pc;
    @(negedge clk);
  endtask
  initial begin
    rst = 1;
    pred_pc = 32'h60;
    upd_valid = 0;
    upd_pc = 0;
    upd_index = 0;
    upd_is_br = 0;
    upd_is_jump = 0;
    upd_taken = 0;
    upd_target = 0;
    upd_mispredict = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    at(32'h60);
    chk("rst_hit", {31'd0, hit[0]}, 0);
    chk("rst_taken", {31'd0, tk[0]}, 0);
    chk("rst_target", tgt[0], 32'h64);
    chk("rst_index", {26'd0, idx[0]}, 32'h18);
    chk("rst_perf_br", pb[0], 0);
    #1 upd(32'h60, 6'h18, 1, 0, 1, 32'h100, 1);
    at(32'h60);
    chk("alloc_hit", {31'd0, hit[0]}, 1);
    chk("alloc_taken", {31'd0, tk[0]}, 1);
    chk("alloc_target", tgt[0], 32'h100);
    chk("gs_index", {26'd0, idx[1]}, 32'h19);
    chk("gs_taken", {31'd0, tk[1]}, 0);
    #1 upd(32'h60, 6'h18, 0, 0, 1, 32'h500, 1);
    at(32'h60);
    chk("noflag_gs_index", {26'd0, idx[1]}, 32'h19);
    chk("noflag_perf_br", pb[0], 1);
    chk("noflag_perf_mis", pm[0], 1);
    chk("noflag_target", tgt[0], 32'h100);
    repeat (2) begin
      #1 upd(32'h60, 6'h18, 1, 0, 0, 32'h0, 0);
    end
    at(32'h60);
    chk("nt2_hit", {31'd0, hit[0]}, 1);
    chk("nt2_taken", {31'd0, tk[0]}, 0);
    chk("nt2_target", tgt[0], 32'h64);
    #1 upd(32'h60, 6'h18, 1, 0, 0, 32'h0, 0);
    at(32'h60);
    chk("nt3_taken", {31'd0, tk[0]}, 0);
    repeat (4) begin
      #1 upd(32'h60, 6'h18, 1, 0, 1, 32'h100, 0);
    end
    at(32'h60);
    chk("t4_taken", {31'd0, tk[0]}, 1);
    #1 upd(32'h60, 6'h18, 1, 0, 0, 32'h0, 0);
    at(32'h60);
    chk("sat_nt1_taken", {31'd0, tk[0]}, 1);
    #1 upd(32'h60, 6'h18, 1, 0, 0, 32'h0, 0);
    at(32'h60);
    chk("sat_nt2_taken", {31'd0, tk[0]}, 0);
    #1 upd(32'h200, 6'h0, 0, 1, 1, 32'h80, 1);
    at(32'h200);
    chk("jump_taken", {31'd0, tk[0]}, 1);
    chk("jump_target", tgt[0], 32'h80);
    #1 at(32'h1060);
    chk("alias_hit", {31'd0, hit[0]}, 0);
    chk("alias_target", tgt[0], 32'h1064);
    #1 upd(32'h204, 6'h1, 1, 1, 1, 32'h40, 0);
    at(32'h204);
    chk("both_jump_taken", {31'd0, tk[0]}, 1);
    chk("both_jump_target", tgt[0], 32'h40);
    #1 rst = 1;
    upd(32'h60, 6'h18, 1, 0, 1, 32'h300, 1);
    rst = 0;
    at(32'h60);
    chk("rst2_hit", {31'd0, hit[0]}, 0);
    chk("rst2_taken", {31'd0, tk[0]}, 0);
    chk("rst2_target", tgt[0], 32'h64);
    chk("rst2_index", {26'd0, idx[0]}, 32'h18);
    chk("rst2_gs_index", {26'd0, idx[1]}, 32'h18);
    chk("rst2_perf_br", pb[0], 0);
    chk("rst2_perf_mis", pm[0], 0);
    #1 upd(32'h60, 6'h18, 1, 0, 1, 32'h100, 0);
    upd(32'h64, 6'h19, 1, 0, 0, 32'h0, 1);
    upd(32'h200, 6'h0, 0, 1, 1, 32'h80, 1);
    upd(32'h68, 6'h1a, 1, 0, 1, 32'h10, 0);
    upd(32'h60, 6'h18, 1, 0, 0, 32'h0, 0);
    at(32'h60);
    chk("perf_br", pb[0], 5);
    chk("perf_mis", pm[0], 2);
    chk("gs_perf_br", pb[1], 5);
    chk("gs_perf_mis", pm[1], 2);
    #1;
    for (int n = 0; n < 400; n++) begin
      upd_valid = $urandom_range(0, 3) != 0;
      upd_pc = 32'($urandom_range(0, 15)) * 4 + ($urandom_range(0, 1) != 0 ? 32'h1000 : 32'h0);
      upd_index = 6'($urandom_range(0, 63));
      upd_is_br = 1'($urandom_range(0, 1));
      upd_is_jump = $urandom_range(0, 3) == 0;
      upd_taken = 1'($urandom_range(0, 1));
      upd_target = $urandom & 32'hfffffffc;
      upd_mispredict = 1'($urandom_range(0, 1));
      pred_pc = $urandom_range(0, 1) != 0 ? upd_pc : 32'($urandom_range(0, 15)) * 4 + 32'h1000;
      @(posedge clk);
      #1;
    end
    upd_valid = 0;
    @(negedge clk);
    #1 $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
